// File: rtl/stdcore_rfifo_lvl_pkg.sv
// rtl/stdcore_rfifo_lvl_pkg.sv - shared helpers for the level-reporting registered-output FIFO
package stdcore_rfifo_lvl_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic bit params_ok(input int depth, input int pre, input int aw);
      return (depth >= 1) && (pre >= 0) && (pre < depth) &&
             ((longint'(1) << aw) > longint'(depth));
   endfunction

endpackage

// File: rtl/stdcore_rfifo_mem.sv
// rtl/stdcore_rfifo_mem.sv - flop-based circular buffer with non-power-of-two pointer wrap
module stdcore_rfifo_mem
   import stdcore_rfifo_lvl_pkg::*;
#(
   parameter int DW = 8,
   parameter int N  = 3,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          wr,
   input  logic [DW-1:0] wdata,
   input  logic          rd,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] cnt
);

   localparam int PW    = (N > 1) ? clog2(N) : 1;
   localparam int SLOTS = 1 << PW;

   // Slots beyond N exist only so the pointer width indexes the array exactly.
   logic [DW-1:0] mem [SLOTS];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] ptr);
      return (ptr == PW'(N - 1)) ? '0 : ptr + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (clr) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (wr) wptr <= nxt(wptr);
         if (rd) rptr <= nxt(rptr);
         cnt <= cnt + AW'(wr) - AW'(rd);
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];

endmodule

// File: rtl/stdcore_rfifo_lvl.sv
// rtl/stdcore_rfifo_lvl.sv - registered-output val/rdy FIFO with level, flush and early-ready flags
module stdcore_rfifo_lvl
   import stdcore_rfifo_lvl_pkg::*;
#(
   parameter int DW     = 8,
   parameter int DEPTH  = 4,
   parameter int PRE    = 0,
   parameter int AFULL  = 3,
   parameter int AEMPTY = 1,
   parameter int AW     = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [DW-1:0] p,
   input  logic          p_val,
   output logic          p_rdy,
   output logic          p_prdy,
   output logic [DW-1:0] c,
   output logic          c_val,
   input  logic          c_rdy,
   output logic [AW-1:0] lvl,
   output logic          afull,
   output logic          aempty
);

   logic          push;
   logic          pop;
   logic          load_c;
   logic          buf_empty;
   logic          buf_rd;
   logic          buf_wr;
   logic [DW-1:0] buf_head;
   logic [AW-1:0] buf_cnt;

   // All flags decode registered lvl only; nothing passes through from c_rdy.
   assign p_rdy  = lvl < AW'(DEPTH);
   assign p_prdy = (AW'(DEPTH) - lvl) > AW'(PRE);
   assign afull  = lvl >= AW'(AFULL);
   assign aempty = lvl <= AW'(AEMPTY);

   always_comb begin
      push      = p_val & p_rdy;
      pop       = c_val & c_rdy;
      load_c    = ~c_val | pop;
      buf_empty = (buf_cnt == '0);
      buf_rd    = load_c & ~buf_empty;
      buf_wr    = push & ~(load_c & buf_empty);
   end

   generate
      if (DEPTH > 1) begin : g_buf
         stdcore_rfifo_mem #(
            .DW (DW),
            .N  (DEPTH - 1),
            .AW (AW)
         ) u_mem (
            .clk   (clk),
            .clr   (rst | flush),
            .wr    (buf_wr),
            .wdata (p),
            .rd    (buf_rd),
            .rdata (buf_head),
            .cnt   (buf_cnt)
         );
      end else begin : g_nobuf
         logic unused_buf;
         assign buf_head   = '0;
         assign buf_cnt    = '0;
         assign unused_buf = buf_wr ^ buf_rd;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         c     <= '0;
         c_val <= 1'b0;
         lvl   <= '0;
      end else if (flush) begin
         c_val <= 1'b0;
         lvl   <= '0;
      end else begin
         lvl <= lvl + AW'(push) - AW'(pop);
         // Buffer head outranks the incoming word so older data leaves first.
         if (load_c) begin
            if (!buf_empty) begin
               c     <= buf_head;
               c_val <= 1'b1;
            end else if (push) begin
               c     <= p;
               c_val <= 1'b1;
            end else begin
               c_val <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (lvl <= AW'(DEPTH) && params_ok(DEPTH, PRE, AW)) else $stop;
   end

endmodule

// File: tb/tb_stdcore_rfifo_lvl.sv
// tb/tb_stdcore_rfifo_lvl.sv - self-checking bench for stdcore_rfifo_lvl
module tb_stdcore_rfifo_lvl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] p4 = '0, c4;
   logic       p_val4 = 1'b0, c_rdy4 = 1'b0, p_rdy4, p_prdy4, c_val4, afull4, aempty4;
   logic [8:0] lvl4;
   logic [7:0] p3 = '0, c3;
   logic       p_val3 = 1'b0, c_rdy3 = 1'b0, p_rdy3, p_prdy3, c_val3, afull3, aempty3;
   logic [8:0] lvl3;
   logic [7:0] p1 = '0, c1;
   logic       p_val1 = 1'b0, c_rdy1 = 1'b0, p_rdy1, p_prdy1, c_val1, afull1, aempty1;
   logic [8:0] lvl1;

   stdcore_rfifo_lvl #(.DW(8), .DEPTH(4), .PRE(1), .AFULL(3), .AEMPTY(1), .AW(9)) u4 (
      .clk(clk), .rst(rst), .flush(flush), .p(p4), .p_val(p_val4), .p_rdy(p_rdy4),
      .p_prdy(p_prdy4), .c(c4), .c_val(c_val4), .c_rdy(c_rdy4), .lvl(lvl4),
      .afull(afull4), .aempty(aempty4));

   stdcore_rfifo_lvl #(.DW(8), .DEPTH(3), .PRE(0), .AFULL(2), .AEMPTY(1), .AW(9)) u3 (
      .clk(clk), .rst(rst), .flush(flush), .p(p3), .p_val(p_val3), .p_rdy(p_rdy3),
      .p_prdy(p_prdy3), .c(c3), .c_val(c_val3), .c_rdy(c_rdy3), .lvl(lvl3),
      .afull(afull3), .aempty(aempty3));

   stdcore_rfifo_lvl #(.DW(8), .DEPTH(1), .PRE(0), .AFULL(1), .AEMPTY(0), .AW(9)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .p(p1), .p_val(p_val1), .p_rdy(p_rdy1),
      .p_prdy(p_prdy1), .c(c1), .c_val(c_val1), .c_rdy(c_rdy1), .lvl(lvl1),
      .afull(afull1), .aempty(aempty1));

   typedef struct {
      logic       pv;
      logic [7:0] p;
      logic       cr;
      logic [8:0] lvl;
      logic       rdy;
      logic       prdy;
      logic       cval;
      logic [7:0] c;
      logic       af;
      logic       ae;
   } vec_t;

   vec_t vt [13];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic pv, input logic [7:0] d, input logic cr);
      if (sel == 1) begin
         p_val1 = pv; p1 = d; c_rdy1 = cr;
      end else begin
         p_val3 = pv; p3 = d; c_rdy3 = cr;
      end
   endtask

   function automatic logic [8:0] sel_lvl(input int sel);
      return (sel == 1) ? lvl1 : lvl3;
   endfunction
   function automatic logic [7:0] sel_c(input int sel);
      return (sel == 1) ? c1 : c3;
   endfunction
   function automatic logic [2:0] sel_fl(input int sel);
      return (sel == 1) ? {p_rdy1, p_prdy1, c_val1} : {p_rdy3, p_prdy3, c_val3};
   endfunction

   task automatic run_sb(input int sel, input int depth, input int cycles, input bit rnd);
      logic [7:0] sb [$];
      int         mlvl;
      logic [7:0] data;
      logic       pv, cr, push, pop;
      logic [7:0] exp;
      mlvl = 0;
      data = 8'h01;
      for (int n = 0; n < cycles + depth + 2; n++) begin
         if (n >= cycles) begin
            pv = 1'b0; cr = 1'b1;
         end else if (rnd) begin
            pv = ($urandom_range(0, 3) != 0);
            cr = ($urandom_range(0, 2) != 0);
         end else begin
            pv = 1'b1; cr = 1'b1;
         end
         push = pv && (mlvl < depth);
         pop  = cr && (mlvl > 0);
         chk($sformatf("sb%0d.lvl", sel), 32'(sel_lvl(sel)), 32'(mlvl));
         chk($sformatf("sb%0d.flags", sel), 32'(sel_fl(sel)),
             {29'd0, mlvl < depth, mlvl < depth, mlvl > 0});
         if (pop) begin
            exp = sb.pop_front();
            chk($sformatf("sb%0d.data", sel), 32'(sel_c(sel)), 32'(exp));
         end
         if (push) sb.push_back(data);
         drive(sel, pv, data, cr);
         if (push) data++;
         mlvl += int'(push) - int'(pop);
         tick();
      end
      drive(sel, 1'b0, 8'h00, 1'b0);
      chk($sformatf("sb%0d.final_lvl", sel), 32'(sel_lvl(sel)), 32'd0);
   endtask

   initial begin
      vt[0]  = '{1'b1, 8'h11, 1'b0, 9'd1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
      vt[1]  = '{1'b1, 8'h22, 1'b0, 9'd2, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 8'h33, 1'b0, 9'd3, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 8'h44, 1'b0, 9'd4, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
      vt[4]  = '{1'b1, 8'h55, 1'b1, 9'd3, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 8'h00, 1'b1, 9'd2, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0};
      vt[6]  = '{1'b0, 8'h00, 1'b1, 9'd1, 1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1};
      vt[7]  = '{1'b0, 8'h00, 1'b1, 9'd0, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1};
      vt[8]  = '{1'b1, 8'hA5, 1'b0, 9'd1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
      vt[9]  = '{1'b0, 8'h00, 1'b1, 9'd0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
      vt[10] = '{1'b1, 8'h66, 1'b0, 9'd1, 1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 1'b1};
      vt[11] = '{1'b1, 8'h67, 1'b1, 9'd1, 1'b1, 1'b1, 1'b1, 8'h67, 1'b0, 1'b1};
      vt[12] = '{1'b0, 8'h00, 1'b1, 9'd0, 1'b1, 1'b1, 1'b0, 8'h67, 1'b0, 1'b1};

      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst.lvl", 32'(lvl4), 32'd0);
      chk("rst.c", 32'(c4), 32'h00);
      chk("rst.flags", {27'd0, c_val4, p_rdy4, p_prdy4, afull4, aempty4}, 32'b01101);

      for (int i = 0; i < 13; i++) begin
         p_val4 = vt[i].pv; p4 = vt[i].p; c_rdy4 = vt[i].cr;
         tick();
         chk($sformatf("v%0d.lvl", i), 32'(lvl4), 32'(vt[i].lvl));
         chk($sformatf("v%0d.p_rdy", i), 32'(p_rdy4), 32'(vt[i].rdy));
         chk($sformatf("v%0d.p_prdy", i), 32'(p_prdy4), 32'(vt[i].prdy));
         chk($sformatf("v%0d.c_val", i), 32'(c_val4), 32'(vt[i].cval));
         chk($sformatf("v%0d.c", i), 32'(c4), 32'(vt[i].c));
         chk($sformatf("v%0d.afull", i), 32'(afull4), 32'(vt[i].af));
         chk($sformatf("v%0d.aempty", i), 32'(aempty4), 32'(vt[i].ae));
      end
      p_val4 = 1'b0; c_rdy4 = 1'b0;

      // flush at lvl=3 with a simultaneous push and pop
      for (int i = 0; i < 3; i++) begin
         p_val4 = 1'b1; p4 = 8'h81 + 8'(i);
         tick();
      end
      chk("fl.pre_lvl", 32'(lvl4), 32'd3);
      flush = 1'b1; p_val4 = 1'b1; p4 = 8'h77; c_rdy4 = 1'b1;
      tick();
      flush = 1'b0; p_val4 = 1'b0; c_rdy4 = 1'b0;
      chk("fl.lvl", 32'(lvl4), 32'd0);
      chk("fl.c_val", 32'(c_val4), 32'd0);
      chk("fl.c_kept", 32'(c4), 32'h81);
      p_val4 = 1'b1; p4 = 8'h90;
      tick();
      p_val4 = 1'b0;
      chk("fl.next_c", 32'(c4), 32'h90);
      chk("fl.next_lvl", 32'(lvl4), 32'd1);
      c_rdy4 = 1'b1;
      tick();
      c_rdy4 = 1'b0;
      chk("fl.drained", {23'd0, lvl4}, 32'd0);
      chk("fl.drained_c", 32'(c4), 32'h90);

      // reset mid-operation
      for (int i = 0; i < 2; i++) begin
         p_val4 = 1'b1; p4 = 8'h91 + 8'(i);
         tick();
      end
      chk("rs.pre_lvl", 32'(lvl4), 32'd2);
      rst = 1'b1; p_val4 = 1'b1; p4 = 8'h93; c_rdy4 = 1'b1;
      tick();
      rst = 1'b0; p_val4 = 1'b0; c_rdy4 = 1'b0;
      chk("rs.lvl", 32'(lvl4), 32'd0);
      chk("rs.c", 32'(c4), 32'h00);
      chk("rs.flags", {27'd0, c_val4, p_rdy4, p_prdy4, afull4, aempty4}, 32'b01101);
      p_val4 = 1'b1; p4 = 8'h94;
      tick();
      p_val4 = 1'b0; c_rdy4 = 1'b1;
      chk("rs.next_c", 32'(c4), 32'h94);
      tick();
      c_rdy4 = 1'b0;
      chk("rs.drained", 32'(lvl4), 32'd0);

      run_sb(3, 3, 200, 1'b1);
      run_sb(1, 1, 20, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
